// File: rtl/execution_sequencer.sv
// Multi-cycle control sequencer for the CPU datapath: fetch, decode, execute, load/store and
// branch refill. Drives per-state strobes for the address register, memory, data register,
// register bank and CPSR write-back. HALT and FAULT are terminal until reset.
module execution_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ins_class,
  input  logic        cond_pass,
  input  logic        s_bit,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic [1:0]  addr_sel,
  output logic        incr_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic        datareg_load,
  output logic        reg_write,
  output logic        set_flags,
  output logic        pc_change,
  output logic        link_write,
  output logic        halted,
  output logic        fault,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StDecode    = 4'd1,
    StExecute   = 4'd2,
    StMemAddr   = 4'd3,
    StMemWait   = 4'd4,
    StWriteback = 4'd5,
    StFill1     = 4'd6,
    StFill2     = 4'd7,
    StHalt      = 4'd8,
    StFault     = 4'd9
  } state_e;

  localparam logic [2:0] ClsDp  = 3'd0;
  localparam logic [2:0] ClsMul = 3'd1;
  localparam logic [2:0] ClsLdr = 3'd2;
  localparam logic [2:0] ClsStr = 3'd3;
  localparam logic [2:0] ClsB   = 3'd4;
  localparam logic [2:0] ClsBl  = 3'd5;
  localparam logic [2:0] ClsSwi = 3'd6;
  localparam logic [2:0] ClsUnd = 3'd7;

  localparam logic [1:0] SelIncr = 2'd0;
  localparam logic [1:0] SelAlu  = 2'd1;
  localparam logic [1:0] SelPc   = 2'd2;

  // Last permitted waiting-cycle count before the access is declared dead.
  localparam logic [3:0] TimeoutLast = 4'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  cls_q, cls_d;
  logic [31:0] retired_q;
  logic        halted_q, fault_q;
  logic        retire;
  logic        timeout_hit;
  logic        is_store;

  // Instruction class is captured in DECODE so later states do not depend on the decoder
  // holding its output stable.
  assign is_store    = (cls_q == ClsStr);
  assign timeout_hit = (cnt_q == TimeoutLast);

  // Next-state, class capture and retirement decision.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StFault;
      end
      StDecode: begin
        cls_d = ins_class;
        if (ins_class == ClsUnd) begin
          state_d = StFault;
        end else if (!cond_pass) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (ins_class == ClsSwi) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        unique case (cls_q)
          ClsDp, ClsMul: begin
            retire  = 1'b1;
            state_d = StFetch;
          end
          ClsLdr, ClsStr: state_d = StMemAddr;
          ClsB, ClsBl:    state_d = StFill1;
          default:        state_d = StFault;
        endcase
      end
      StMemAddr: state_d = StMemWait;
      StMemWait: begin
        if (mem_ready) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end else if (timeout_hit) begin
          state_d = StFault;
        end
      end
      StWriteback: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StFill1: state_d = StFill2;
      StFill2: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  // Wait counter runs only while stalled in an access state; any state change clears it.
  always_comb begin
    cnt_d = 4'd0;
    if ((state_d == state_q) && ((state_q == StFetch) || (state_q == StMemWait))) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // State, counters and sticky status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      cnt_q     <= 4'd0;
      cls_q     <= ClsDp;
      retired_q <= 32'd0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      retired_q <= retired_q + 32'(retire);
      halted_q  <= halted_q | (state_d == StHalt);
      fault_q   <= fault_q | (state_d == StFault);
    end
  end

  // Per-state strobes; forced to the idle pattern while reset is asserted so a reset
  // mid-access drops the memory strobes immediately.
  always_comb begin
    ir_load      = 1'b0;
    addr_sel     = SelPc;
    incr_en      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    datareg_load = 1'b0;
    reg_write    = 1'b0;
    set_flags    = 1'b0;
    pc_change    = 1'b0;
    link_write   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          addr_sel = SelIncr;
          incr_en  = 1'b1;
          ir_load  = mem_ready;
        end
        StExecute: begin
          if ((cls_q == ClsDp) || (cls_q == ClsMul)) begin
            reg_write = 1'b1;
            set_flags = s_bit;
          end else if ((cls_q == ClsB) || (cls_q == ClsBl)) begin
            pc_change  = 1'b1;
            addr_sel   = SelAlu;
            link_write = (cls_q == ClsBl);
          end
        end
        StMemAddr: begin
          addr_sel     = SelAlu;
          datareg_load = is_store;
        end
        StMemWait: begin
          mem_read  = !is_store;
          mem_write = is_store;
          addr_sel  = SelAlu;
          if (mem_ready) begin
            if (is_store) addr_sel     = SelPc;
            else          datareg_load = 1'b1;
          end
        end
        StWriteback: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted  = halted_q;
  assign fault   = fault_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
